// File: rtl/ff_regfile_pkg.sv
// Shared types and helpers for the ff_regfile_mp register file.
// Clear-engine state encoding and the byte-enable merge used by every row.
package ff_regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // Widest row the merge helper supports; callers zero-extend narrower rows.
    localparam int unsigned MAX_WIDTH = 1024;

    function automatic logic [MAX_WIDTH-1:0] merge_be(
        input logic [MAX_WIDTH-1:0]   old_v,
        input logic [MAX_WIDTH-1:0]   new_v,
        input logic [MAX_WIDTH/8-1:0] be
    );
        logic [MAX_WIDTH-1:0] res;
        res = old_v;
        for (int unsigned b = 0; b < MAX_WIDTH/8; b++) begin
            if (be[b]) begin
                res[b*8 +: 8] = new_v[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ff_regfile_row.sv
// One storage row of ff_regfile_mp: priority-merges all write ports into the next value.
// Exposes the post-write value for reads when REGFILE_BYPASS_EN is defined, else the stored value.
module ff_regfile_row
    import ff_regfile_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_WR = 2,
    parameter int unsigned AW     = 4,
    parameter int unsigned ROW    = 0
)
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr_i,
    input  logic                        wr_block_i,
    input  logic [NUM_WR-1:0]           wr_en_i,
    input  logic [NUM_WR*AW-1:0]        wr_addr_i,
    input  logic [NUM_WR*WIDTH/8-1:0]   wr_be_i,
    input  logic [NUM_WR*WIDTH-1:0]     wr_data_i,
    output logic [WIDTH-1:0]            row_rd_o
);

    localparam int unsigned BW = WIDTH / 8;
    localparam logic [AW-1:0] ROW_ADDR = AW'(ROW);

    logic [WIDTH-1:0]       row_q;
    logic [WIDTH-1:0]       row_d;
    logic [MAX_WIDTH-1:0]   acc;
    logic [MAX_WIDTH-1:0]   data_ext;
    logic [MAX_WIDTH/8-1:0] be_ext;

    // Ports are folded in ascending order so the highest-numbered port wins each byte.
    always_comb begin
        acc      = '0;
        data_ext = '0;
        be_ext   = '0;
        acc[WIDTH-1:0] = row_q;
        for (int unsigned p = 0; p < NUM_WR; p++) begin
            data_ext = '0;
            be_ext   = '0;
            data_ext[WIDTH-1:0] = wr_data_i[p*WIDTH +: WIDTH];
            be_ext[BW-1:0]      = wr_be_i[p*BW +: BW];
            if (wr_en_i[p] && !wr_block_i && (wr_addr_i[p*AW +: AW] == ROW_ADDR)) begin
                acc = merge_be(acc, data_ext, be_ext);
            end
        end
        row_d = clr_i ? '0 : acc[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
        end else begin
            row_q <= row_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign row_rd_o = row_d;
`else
    assign row_rd_o = row_q;
`endif

endmodule

// File: rtl/ff_regfile_mp.sv
// Flip-flop multi-port register file with registered reads and a row-by-row clear engine.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module ff_regfile_mp
    import ff_regfile_pkg::*;
#(
    parameter  int unsigned WIDTH  = 32,
    parameter  int unsigned DEPTH  = 16,
    parameter  int unsigned NUM_WR = 2,
    parameter  int unsigned NUM_RD = 2,
    localparam int unsigned AW     = $clog2(DEPTH),
    localparam int unsigned BW     = WIDTH / 8
)
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_WR-1:0]         wr_en,
    input  logic [NUM_WR*AW-1:0]      wr_addr,
    input  logic [NUM_WR*BW-1:0]      wr_be,
    input  logic [NUM_WR*WIDTH-1:0]   wr_data,
    input  logic [NUM_RD-1:0]         rd_en,
    input  logic [NUM_RD*AW-1:0]      rd_addr,
    output logic [NUM_RD*WIDTH-1:0]   rd_data,
    output logic [NUM_RD-1:0]         rd_valid,
    input  logic                      clr_req,
    output logic                      clr_busy
);

    clr_state_t                state_q;
    logic [AW-1:0]             cnt_q;
    logic                      clr_busy_q;
    logic [DEPTH-1:0]          row_clr;
    logic [WIDTH-1:0]          row_rd [DEPTH];
    logic [NUM_RD*WIDTH-1:0]   rd_data_q;
    logic [NUM_RD*WIDTH-1:0]   rd_data_d;
    logic [NUM_RD-1:0]         rd_valid_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_row
        assign row_clr[i] = (state_q == CLEAR) && (cnt_q == AW'(i));

        ff_regfile_row #(
            .WIDTH  (WIDTH),
            .NUM_WR (NUM_WR),
            .AW     (AW),
            .ROW    (i)
        ) u_row (
            .clk        (clk),
            .rst_n      (rst_n),
            .clr_i      (row_clr[i]),
            .wr_block_i (clr_busy_q),
            .wr_en_i    (wr_en),
            .wr_addr_i  (wr_addr),
            .wr_be_i    (wr_be),
            .wr_data_i  (wr_data),
            .row_rd_o   (row_rd[i])
        );
    end

    // Addresses at or beyond DEPTH match no row and therefore read as zero.
    always_comb begin
        rd_data_d = rd_data_q;
        for (int unsigned r = 0; r < NUM_RD; r++) begin
            if (rd_en[r]) begin
                rd_data_d[r*WIDTH +: WIDTH] = '0;
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (rd_addr[r*AW +: AW] == AW'(i)) begin
                        rd_data_d[r*WIDTH +: WIDTH] = row_rd[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= '0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            clr_busy_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr_req) begin
                        state_q    <= CLEAR;
                        clr_busy_q <= 1'b1;
                        cnt_q      <= '0;
                    end
                end
                CLEAR: begin
                    if (cnt_q == AW'(DEPTH - 1)) begin
                        state_q    <= IDLE;
                        clr_busy_q <= 1'b0;
                        cnt_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q + AW'(1);
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    clr_busy_q <= 1'b0;
                    cnt_q      <= '0;
                end
            endcase
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign clr_busy = clr_busy_q;

endmodule

// File: tb/tb_ff_regfile_mp.sv
// Bench for ff_regfile_mp: a DEPTH=16 and a DEPTH=12 instance share all inputs.
// Read expectations go through a scoreboard queue fed from a bench-side row model.
module tb_ff_regfile_mp;

    localparam int W  = 32;
    localparam int NW = 2;
    localparam int NR = 2;
    localparam int AW = 4;
    localparam int BW = 4;
    localparam int DA = 16;
    localparam int DB = 12;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NW-1:0]    wr_en;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*BW-1:0] wr_be;
    logic [NW*W-1:0]  wr_data;
    logic [NR-1:0]    rd_en;
    logic [NR*AW-1:0] rd_addr;
    logic             clr_req;
    logic [NR*W-1:0]  rd_data_a, rd_data_b;
    logic [NR-1:0]    rd_valid_a, rd_valid_b;
    logic             clr_busy_a, clr_busy_b;

    always #5 clk = ~clk;

    ff_regfile_mp #(.WIDTH(W), .DEPTH(DA), .NUM_WR(NW), .NUM_RD(NR)) u_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .rd_valid(rd_valid_a), .clr_req(clr_req), .clr_busy(clr_busy_a)
    );

    ff_regfile_mp #(.WIDTH(W), .DEPTH(DB), .NUM_WR(NW), .NUM_RD(NR)) u_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_valid(rd_valid_b), .clr_req(clr_req), .clr_busy(clr_busy_b)
    );

    typedef struct {
        int          dut;
        int          port;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [1:0]  we;
        logic [3:0]  a0;
        logic [3:0]  be0;
        logic [31:0] d0;
        logic [3:0]  a1;
        logic [3:0]  be1;
        logic [31:0] d1;
        logic [3:0]  ra;
        logic [31:0] exp;
    } vec_t;

    exp_t        sb_q[$];
    logic [31:0] mem_a [DA];
    logic [31:0] mem_b [DB];
    logic [31:0] held [2][NR];
    bit          wr_block;
    int          checks = 0;
    int          errors = 0;
    vec_t        vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_en   = '0;
        wr_addr = '0;
        wr_be   = '0;
        wr_data = '0;
        rd_en   = '0;
        rd_addr = '0;
        clr_req = 1'b0;
    endtask

    task automatic set_wr(input int p, input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
        wr_en[p]              = 1'b1;
        wr_addr[p*AW +: AW]   = a;
        wr_be[p*BW +: BW]     = be;
        wr_data[p*W +: W]     = d;
    endtask

    task automatic set_rd(input int r, input logic [3:0] a);
        rd_en[r]            = 1'b1;
        rd_addr[r*AW +: AW] = a;
    endtask

    task automatic zero_model();
        for (int i = 0; i < DA; i++) mem_a[i] = '0;
        for (int i = 0; i < DB; i++) mem_b[i] = '0;
    endtask

    task automatic model_writes();
        int a;
        if (wr_block) return;
        for (int p = 0; p < NW; p++) begin
            if (wr_en[p]) begin
                a = int'(wr_addr[p*AW +: AW]);
                for (int b = 0; b < BW; b++) begin
                    if (wr_be[p*BW + b]) begin
                        if (a < DA) mem_a[a][b*8 +: 8] = wr_data[p*W + b*8 +: 8];
                        if (a < DB) mem_b[a][b*8 +: 8] = wr_data[p*W + b*8 +: 8];
                    end
                end
            end
        end
    endtask

    task automatic push_reads();
        int   a;
        exp_t e;
        for (int r = 0; r < NR; r++) begin
            if (rd_en[r]) begin
                a = int'(rd_addr[r*AW +: AW]);
                e.port = r;
                e.dut  = 0;
                e.data = (a < DA) ? mem_a[a] : 32'h0;
                sb_q.push_back(e);
                e.dut  = 1;
                e.data = (a < DB) ? mem_b[a] : 32'h0;
                sb_q.push_back(e);
            end
        end
    endtask

    // One clock: record expectations, advance past the edge, compare every read port.
    task automatic tick();
        logic [NR-1:0] mask;
        exp_t          e;
        mask = rd_en;
`ifdef REGFILE_BYPASS_EN
        model_writes();
        push_reads();
`else
        push_reads();
        model_writes();
`endif
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            held[e.dut][e.port] = e.data;
        end
        chk("rd_valid_a", 32'(rd_valid_a), 32'(mask));
        chk("rd_valid_b", 32'(rd_valid_b), 32'(mask));
        for (int r = 0; r < NR; r++) begin
            chk($sformatf("rd_data_a[%0d]", r), rd_data_a[r*W +: W], held[0][r]);
            chk($sformatf("rd_data_b[%0d]", r), rd_data_b[r*W +: W], held[1][r]);
        end
        idle_inputs();
    endtask

    task automatic read_all();
        for (int a = 0; a < DA; a++) begin
            set_rd(0, 4'(a));
            set_rd(1, 4'(DA - 1 - a));
            tick();
        end
    endtask

    task automatic reset_bench_state();
        zero_model();
        wr_block = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < NR; r++) held[d][r] = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_a;
        int cnt_b;
        logic [31:0] same_exp;

        vecs[0] = '{2'b01, 4'd3,  4'hF, 32'hAAAA_AAAA, 4'd0, 4'h0, 32'h0,          4'd3,  32'hAAAA_AAAA};
        vecs[1] = '{2'b10, 4'd0,  4'h0, 32'h0,         4'd3, 4'h3, 32'h1234_5678,  4'd3,  32'hAAAA_5678};
        vecs[2] = '{2'b11, 4'd5,  4'hF, 32'h1111_1111, 4'd5, 4'hF, 32'h2222_2222,  4'd5,  32'h2222_2222};
        vecs[3] = '{2'b11, 4'd6,  4'h3, 32'h1111_BBBB, 4'd6, 4'hC, 32'hCCCC_2222,  4'd6,  32'hCCCC_BBBB};
        vecs[4] = '{2'b11, 4'd8,  4'hF, 32'h1122_3344, 4'd8, 4'h6, 32'hAABB_CCDD,  4'd8,  32'h11BB_CC44};
        vecs[5] = '{2'b01, 4'd3,  4'h0, 32'hFFFF_FFFF, 4'd0, 4'h0, 32'h0,          4'd3,  32'hAAAA_5678};
        vecs[6] = '{2'b11, 4'd13, 4'hF, 32'h0D0D_0D0D, 4'd1, 4'hF, 32'h0101_0101,  4'd13, 32'h0D0D_0D0D};
        vecs[7] = '{2'b10, 4'd0,  4'h0, 32'h0,         4'd15, 4'hF, 32'hFFFF_FFFF, 4'd15, 32'hFFFF_FFFF};

        idle_inputs();
        reset_bench_state();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset rd_valid_a", 32'(rd_valid_a), 32'h0);
        chk("reset rd_data_a", rd_data_a[31:0] | rd_data_a[63:32], 32'h0);
        chk("reset clr_busy_a", 32'(clr_busy_a), 32'h0);
        chk("reset clr_busy_b", 32'(clr_busy_b), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        read_all();

        for (int v = 0; v < 8; v++) begin
            if (vecs[v].we[0]) set_wr(0, vecs[v].a0, vecs[v].be0, vecs[v].d0);
            if (vecs[v].we[1]) set_wr(1, vecs[v].a1, vecs[v].be1, vecs[v].d1);
            tick();
            set_rd(0, vecs[v].ra);
            set_rd(1, vecs[v].ra);
            tick();
            chk($sformatf("vec%0d row", v), rd_data_a[31:0], vecs[v].exp);
        end

        set_rd(0, 4'd13);
        set_rd(1, 4'd1);
        tick();
        chk("b addr13 data", rd_data_b[31:0], 32'h0);
        chk("b addr13 valid", 32'(rd_valid_b[0]), 32'h1);
        chk("b row1 untouched by addr13", rd_data_b[63:32], 32'h0101_0101);
        read_all();

`ifdef REGFILE_BYPASS_EN
        same_exp = 32'hDEAD_BEEF;
`else
        same_exp = 32'h0;
`endif
        set_wr(0, 4'd7, 4'hF, 32'hDEAD_BEEF);
        set_rd(0, 4'd7);
        tick();
        chk("same-cycle rw row7", rd_data_a[31:0], same_exp);
        set_rd(0, 4'd7);
        tick();
        chk("row7 after write", rd_data_a[31:0], 32'hDEAD_BEEF);

        for (int a = 0; a < DA; a++) begin
            set_wr(0, 4'(a), 4'hF, 32'h0101_0101 * (a + 1));
            tick();
        end
        read_all();

        clr_req = 1'b1;
        set_wr(1, 4'd15, 4'hF, 32'h5A5A_0F0F);
        tick();
        chk("clr_busy rise a", 32'(clr_busy_a), 32'h1);
        chk("clr_busy rise b", 32'(clr_busy_b), 32'h1);
        cnt_a = int'(clr_busy_a);
        cnt_b = int'(clr_busy_b);
        wr_block = 1'b1;
        for (int k = 0; k < 40 && (clr_busy_a || clr_busy_b); k++) begin
            if (k == 0) set_rd(0, 4'd15);
            if (k >= 1 && k < 8) begin
                set_wr(0, 4'd0, 4'hF, 32'hFFFF_FFFF);
                set_wr(1, 4'd1, 4'hF, 32'hEEEE_EEEE);
            end
            if (k == 3) clr_req = 1'b1;
            tick();
            if (k == 0) chk("clr-cycle write row15", rd_data_a[31:0], 32'h5A5A_0F0F);
            if (clr_busy_a) cnt_a++;
            if (clr_busy_b) cnt_b++;
        end
        chk("clr_busy cycles a", 32'(cnt_a), 32'd16);
        chk("clr_busy cycles b", 32'(cnt_b), 32'd12);
        wr_block = 1'b0;
        zero_model();
        read_all();

        set_wr(0, 4'd4, 4'hF, 32'hCAFE_F00D);
        tick();
        clr_req = 1'b1;
        tick();
        wr_block = 1'b1;
        tick();
        tick();
        chk("busy before mid-clear reset", 32'(clr_busy_a), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid-clear reset busy a", 32'(clr_busy_a), 32'h0);
        chk("mid-clear reset busy b", 32'(clr_busy_b), 32'h0);
        chk("mid-clear reset valid", 32'(rd_valid_a), 32'h0);
        reset_bench_state();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        read_all();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
